// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 wait-state memory model.
// Optional out-of-range error flag: LC3_MEM_ERR_EN.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  localparam int LAT_W      = 4;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 65536;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous word array with registered read data.
// Optional out-of-range error flag: LC3_MEM_ERR_EN.
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              ok,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = ok ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (en && we && ok) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_ws.sv
// LC3 main memory with ready handshake and programmable wait states.
// Optional sticky out-of-range flag mem_err: LC3_MEM_ERR_EN.
module lc3_mem_ws
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata,
`ifdef LC3_MEM_ERR_EN
  output logic              mem_rdy,
  output logic              mem_err
`else
  output logic              mem_rdy
`endif
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [LAT_W-1:0] RD_L = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] WR_L = LAT_W'(WR_LAT);
  localparam logic [LAT_W-1:0] ONE  = LAT_W'(1);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  mem_state_t        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_q, rdy_d;

  logic              cm_en;
  logic              cm_we;
  logic              cm_ok;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_data;

  // cm_* is the commit on the edge entering DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    lat     = RD_L;
    cm_en   = 1'b0;
    cm_we   = we_q;
    cm_addr = addr_q;
    cm_data = data_q;
    unique case (state_q)
      IDLE: begin
        if (mem_en) begin
          we_d   = we;
          addr_d = addr;
          data_d = data;
          lat    = we ? WR_L : RD_L;
          cnt_d  = lat - ONE;
          if (lat == ONE) begin
            state_d = DONE;
            cm_en   = 1'b1;
            cm_we   = we;
            cm_addr = addr;
            cm_data = data;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = DONE;
          cm_en   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      cm_en = 1'b0;
    end
    rdy_d = cm_en;
    cm_ok = {1'b0, cm_addr} < DEPTH_V;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  assign mem_rdy = rdy_q;

`ifdef LC3_MEM_ERR_EN
  logic mem_err_q, mem_err_d;

  always_comb begin
    mem_err_d = mem_err_q | (cm_en & ~cm_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= mem_err_d;
      if (cm_en && !cm_ok) begin
        $error("lc3_mem_ws: out-of-range addr %h", cm_addr);
      end
    end
  end

  assign mem_err = mem_err_q;
`endif

  lc3_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) iARR (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cm_en),
    .we    (cm_we),
    .ok    (cm_ok),
    .idx   (cm_addr[IDX_W-1:0]),
    .wdata (cm_data),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_lc3_mem_ws.sv
// Directed bench for lc3_mem_ws across several latency/depth builds.
// Optional out-of-range error flag checked when LC3_MEM_ERR_EN is set.
module tb_lc3_mem_ws;

  localparam int N = 5;
  localparam int RDL [N] = '{1, 4, 5, 2, 1};
  localparam int WRL [N] = '{1, 3, 4, 2, 1};
  localparam int DEP [N] = '{65536, 65536, 65536, 65536, 256};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_en [N];
  logic        we     [N];
  logic [15:0] addr   [N];
  logic [15:0] data   [N];
  logic [15:0] rdata  [N];
  logic        rdy    [N];
`ifdef LC3_MEM_ERR_EN
  logic        err    [N];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    lc3_mem_ws #(
      .DATA_W (16),
      .ADDR_W (16),
      .DEPTH  (DEP[i]),
      .RD_LAT (RDL[i]),
      .WR_LAT (WRL[i])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem_en  (mem_en[i]),
      .we      (we[i]),
      .addr    (addr[i]),
      .data    (data[i]),
      .rdata   (rdata[i]),
`ifdef LC3_MEM_ERR_EN
      .mem_rdy (rdy[i]),
      .mem_err (err[i])
`else
      .mem_rdy (rdy[i])
`endif
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic w,
                       input logic [15:0] a,
                       input logic [15:0] d);
    mem_en[k] = 1'b1;
    we[k]     = w;
    addr[k]   = a;
    data[k]   = d;
  endtask

  // Count negedges until mem_rdy; caller sits on a negedge
  task automatic wait_rdy(input int k, input int exp_n,
                          input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[k] && n < 40);
    chk(tag, n, exp_n);
  endtask

  task automatic access(input int k, input logic w,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        input int lat, input string tag);
    drive(k, w, a, d);
    wait_rdy(k, lat, tag);
    mem_en[k] = 1'b0;
  endtask

  task automatic count_rdy(input int k, input int cyc,
                           input string tag);
    int p;
    p = 0;
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      if (rdy[k]) p++;
    end
    chk(tag, p, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_en[i] = 1'b0;
      we[i]     = 1'b0;
      addr[i]   = '0;
      data[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy[0], 0);
    chk("rst_rdata", rdata[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single-cycle read
    access(0, 1, 16'h3000, 16'h1234, 1, "t1_wlat");
    @(negedge clk);
    access(0, 0, 16'h3000, 16'h0, 1, "t1_rlat");
    chk("t1_rdata", rdata[0], 16'h1234);
    repeat (2) @(negedge clk);
    chk("t1_hold", rdata[0], 16'h1234);
    chk("t1_norepeat", rdy[0], 0);

    // 2: write then read with mem_en held
    drive(1, 1, 16'h4000, 16'hBEEF);
    wait_rdy(1, 3, "t2_wlat");
    we[1] = 1'b0;
    data[1] = 16'h0;
    wait_rdy(1, 5, "t2_rlat");
    mem_en[1] = 1'b0;
    chk("t2_rdata", rdata[1], 16'hBEEF);

    // 3: mem_en and addr change during BUSY are ignored
    access(2, 1, 16'h3100, 16'h5A5A, 4, "t3_pre1");
    @(negedge clk);
    access(2, 1, 16'h0000, 16'h0F0F, 4, "t3_pre2");
    @(negedge clk);
    drive(2, 0, 16'h3100, 16'h0);
    @(negedge clk);
    mem_en[2] = 1'b0;
    addr[2] = 16'h0000;
    wait_rdy(2, 4, "t3_lat");
    chk("t3_rdata", rdata[2], 16'h5A5A);
    count_rdy(2, 10, "t3_extra");

    // 4: reset during a pending write discards it
    access(2, 1, 16'h5000, 16'h1111, 4, "t4_pre");
    @(negedge clk);
    drive(2, 1, 16'h5000, 16'hAAAA);
    @(negedge clk);
    chk("t4_busy_rdy", rdy[2], 0);
    @(negedge clk);
    rst_n = 1'b0;
    mem_en[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_rdata_rst", rdata[2], 0);
    count_rdy(2, 8, "t4_norsp");
    access(2, 0, 16'h5000, 16'h0, 5, "t4_rlat");
    chk("t4_rdata", rdata[2], 16'h1111);

    // 5: out-of-range on a 256-word build
    access(4, 1, 16'h0000, 16'h3333, 1, "t5_w0");
    @(negedge clk);
    access(4, 1, 16'h0100, 16'h7777, 1, "t5_woor");
    @(negedge clk);
`ifdef LC3_MEM_ERR_EN
    chk("t5_err_set", err[4], 1);
`endif
    access(4, 0, 16'h0000, 16'h0, 1, "t5_r0lat");
    chk("t5_r0", rdata[4], 16'h3333);
    @(negedge clk);
    access(4, 0, 16'h0100, 16'h0, 1, "t5_roorlat");
    chk("t5_roor", rdata[4], 16'h0000);
    @(negedge clk);
    access(4, 1, 16'h00FF, 16'h2222, 1, "t5_wff");
    @(negedge clk);
    access(4, 0, 16'h00FF, 16'h0, 1, "t5_rfflat");
    chk("t5_rff", rdata[4], 16'h2222);
`ifdef LC3_MEM_ERR_EN
    chk("t5_err_sticky", err[4], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_err_clr", err[4], 0);
`endif

    // 6: four back-to-back reads, RD_LAT=2
    for (int j = 0; j < 4; j++) begin
      access(3, 1, 16'h0010 + 16'(j), 16'hC000 + 16'(j * 3), 2, "t6_pre");
      @(negedge clk);
    end
    drive(3, 0, 16'h0010, 16'h0);
    for (int j = 0; j < 4; j++) begin
      wait_rdy(3, (j == 0) ? 2 : 3, "t6_lat");
      chk("t6_rdata", rdata[3], 16'hC000 + 16'(j * 3));
      if (j == 3) mem_en[3] = 1'b0;
      else addr[3] = 16'h0011 + 16'(j);
    end
    count_rdy(3, 8, "t6_extra");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
